// File: rtl/result_window_acc.sv
// Windowed accumulator: sums WINDOW accepted samples, reports sum, average and (optionally) max.
// Define RESULT_WINDOW_ACC_MAX_EN to build the running-max tracker; otherwise max is tied to 0.
module result_window_acc #(
  parameter int unsigned WINDOW = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [8:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic [12:0] sum,
  output logic [8:0]  avg,
  output logic [8:0]  max,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned SHIFT = $clog2(WINDOW);
  localparam int unsigned CNT_W = SHIFT + 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [12:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [12:0]      sum_q, sum_d;
  logic [8:0]       avg_q, avg_d;
  logic [12:0]      acc_next;
  logic             last;
  logic             take;
  logic             done;
  logic             drop;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign avg       = avg_q;

  assign acc_next = acc_q + 13'(in_data);
  assign last     = (cnt_q == CNT_W'(WINDOW - 1));
  // clear beats a coincident sample; handover clears the window
  assign take     = (state_q == ACCUM) && in_valid && !clear;
  assign done     = take && last;
  assign drop     = ((state_q == ACCUM) && clear) || ((state_q == HOLD) && out_ready);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    if (drop) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ACCUM;
    end else if (take) begin
      acc_d = acc_next;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        sum_d   = acc_next;
        avg_d   = 9'(acc_next >> SHIFT);
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
    end
  end

`ifdef RESULT_WINDOW_ACC_MAX_EN
  logic [8:0] rmax_q, rmax_d;
  logic [8:0] max_q, max_d;
  logic [8:0] max_next;

  assign max_next = (in_data > rmax_q) ? in_data : rmax_q;
  assign max      = max_q;

  always_comb begin
    rmax_d = rmax_q;
    max_d  = max_q;
    if (drop) begin
      rmax_d = '0;
    end else if (take) begin
      rmax_d = max_next;
      if (done) max_d = max_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rmax_q <= '0;
      max_q  <= '0;
    end else begin
      rmax_q <= rmax_d;
      max_q  <= max_d;
    end
  end
`else
  assign max = '0;
`endif

endmodule

// File: tb/tb_result_window_acc.sv
// Scoreboard bench for result_window_acc (WINDOW=4); expected max follows RESULT_WINDOW_ACC_MAX_EN.
module tb_result_window_acc;

  localparam int unsigned WINDOW = 4;
`ifdef RESULT_WINDOW_ACC_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [8:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [12:0] sum;
  logic [8:0]  avg;
  logic [8:0]  mx;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [12:0] s;
    logic [8:0]  a;
    logic [8:0]  m;
  } res_t;

  res_t        exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned m_acc, m_cnt, m_max;

  result_window_acc #(.WINDOW(WINDOW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .sum       (sum),
    .avg       (avg),
    .max       (mx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_max = 0;
  endtask

  task automatic model_accept(input logic [8:0] d);
    res_t r;
    m_acc += d;
    if (d > m_max) m_max = d;
    m_cnt++;
    if (m_cnt == WINDOW) begin
      r.s = 13'(m_acc);
      r.a = 9'(m_acc / WINDOW);
      r.m = MAX_EN ? 9'(m_max) : 9'd0;
      exp_q.push_back(r);
      model_reset();
    end
  endtask

  task automatic drive_sample(input logic [8:0] d);
    in_valid = 1'b1;
    in_data  = d;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_accum got %b want 1", in_ready);
    end
    cyc();
    model_accept(d);
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string name);
    res_t e;
    int   waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid got %b want 1 (timeout)", name, out_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s unexpected result got sum=%0d want none", name, sum);
      return;
    end
    e = exp_q.pop_front();
    vectors += 4;
    if (sum !== e.s) begin
      miscompares++;
      $display("FAIL %s sum got %0d want %0d", name, sum, e.s);
    end
    if (avg !== e.a) begin
      miscompares++;
      $display("FAIL %s avg got %0d want %0d", name, avg, e.a);
    end
    if (mx !== e.m) begin
      miscompares++;
      $display("FAIL %s max got %0d want %0d", name, mx, e.m);
    end
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s in_ready_hold got %b want 0", name, in_ready);
    end
  endtask

  task automatic consume_check(input string name);
    out_ready = 1'b1;
    cyc();
    vectors += 2;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s out_valid_after got %b want 0", name, out_valid);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_after got %b want 1", name, in_ready);
    end
  endtask

  task automatic check_idle(input string name);
    vectors += 5;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s out_valid got %b want 0", name, out_valid);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready got %b want 1", name, in_ready);
    end
    if (sum !== 13'd0) begin
      miscompares++;
      $display("FAIL %s sum got %0d want 0", name, sum);
    end
    if (avg !== 9'd0) begin
      miscompares++;
      $display("FAIL %s avg got %0d want 0", name, avg);
    end
    if (mx !== 9'd0) begin
      miscompares++;
      $display("FAIL %s max got %0d want 0", name, mx);
    end
  endtask

  // Asynchronous pulse placed mid-cycle, checked before any clock edge.
  task automatic reset_pulse(input string name);
    #2 reset_n = 1'b0;
    #1 check_idle(name);
    model_reset();
    exp_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s no_pulse got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #3 check_idle("reset");
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_sample(9'd9);
    drive_sample(9'd11);
    drive_sample(9'd18);
    drive_sample(9'd2);
    check_result("basic");
    consume_check("basic");
  endtask

  task automatic test_hold();
    logic [8:0] want_m;
    want_m    = MAX_EN ? 9'd511 : 9'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (2) cyc();
      drive_sample(9'd511);
    end
    check_result("hold");
    // clear and in_valid during HOLD must not disturb the result
    for (int i = 0; i < 5; i++) begin
      clear    = (i == 2);
      in_valid = (i != 2);
      in_data  = 9'd7;
      cyc();
      vectors += 4;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_flags got v=%b r=%b want v=1 r=0", out_valid, in_ready);
      end
      if (sum !== 13'd2044) begin
        miscompares++;
        $display("FAIL hold_sum got %0d want 2044", sum);
      end
      if (avg !== 9'd511) begin
        miscompares++;
        $display("FAIL hold_avg got %0d want 511", avg);
      end
      if (mx !== want_m) begin
        miscompares++;
        $display("FAIL hold_max got %0d want %0d", mx, want_m);
      end
    end
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'd77;
    consume_check("hold_handover");
    in_valid = 1'b0;
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    drive_sample(9'd100);
    drive_sample(9'd200);
    in_valid = 1'b1;
    in_data  = 9'd50;
    clear    = 1'b1;
    cyc();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (4) drive_sample(9'd5);
    check_result("clear");
    consume_check("clear");
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    drive_sample(9'd3);
    drive_sample(9'd4);
    drive_sample(9'd5);
    drive_sample(9'd6);
    check_result("reset_hold_pre");
    reset_pulse("reset_hold");
    out_ready = 1'b1;
    repeat (4) drive_sample(9'd1);
    check_result("reset_hold_post");
    consume_check("reset_hold_post");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_sample(9'd50);
    drive_sample(9'd60);
    reset_pulse("reset_mid");
    drive_sample(9'd1);
    drive_sample(9'd2);
    drive_sample(9'd3);
    drive_sample(9'd4);
    check_result("reset_mid");
    consume_check("reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 6; w++) begin
      out_ready = (w % 2 == 0);
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        drive_sample(9'($urandom_range(0, 511)));
      end
      check_result("random");
      if (!out_ready) repeat ($urandom_range(1, 3)) cyc();
      consume_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_clear();
    test_reset_hold();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_results got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_window_acc.md
RESULT_WINDOW_ACC -- requirements
Module: result_window_acc

Interface
REQ-001 Parameter: WINDOW, default 4, samples per window; SHALL be a power of two in 2..16.
REQ-002 Port: clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  9  result sample from the upstream ALU stage.
REQ-005 Port: in_valid  input  1  in_data is valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-007 Port: clear  input  1  synchronous abort of the current partial window.
REQ-008 Port: sum  output  13  sum of the completed window's samples.
REQ-009 Port: avg  output  9  window average.
REQ-010 Port: max  output  9  largest sample in the completed window.
REQ-011 Port: out_valid  output  1  sum, avg and max hold a completed window.
REQ-012 Port: out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-013 State machine SHALL have exactly two states: ACCUM and HOLD.
REQ-014 In ACCUM: in_ready=1 and out_valid=0.
REQ-015 In HOLD: in_ready=0 and out_valid=1.
REQ-016 A sample is accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On each accepted sample: accumulator += in_data (13-bit, no overflow possible: 16*511 < 8192), running max updated, sample count incremented.
REQ-018 Gaps in in_valid SHALL not affect the accumulator, count or max.
REQ-019 When the WINDOW-th sample is accepted, on that edge: sum, avg and max are loaded with values that include that sample, and the state goes to HOLD. out_valid is therefore high in the cycle after the last accepted sample (latency 1).
REQ-020 avg SHALL equal sum >> log2(WINDOW) (truncation, no rounding).
REQ-021 In HOLD, sum, avg and max SHALL stay stable while out_ready=0, for any number of cycles.
REQ-022 In HOLD with out_ready=1, on that edge: accumulator, count and running max cleared; state goes to ACCUM; out_valid=0 next cycle.
REQ-023 No sample is accepted in the handover cycle.
REQ-024 clear=1 in ACCUM clears accumulator, count and running max on that edge.
REQ-025 If clear=1 and a sample is accepted on the same edge, clear SHALL win and the sample is discarded.
REQ-026 clear=1 in HOLD SHALL be ignored; the result is held until consumed.
REQ-027 out_ready in ACCUM SHALL be ignored.
REQ-028 The running max initial value SHALL be 0, so a window of all-zero samples yields max=0.

Reset
REQ-029 reset_n=0 SHALL immediately, regardless of clock, force: state ACCUM; accumulator, count and running max 0; sum=0, avg=0, max=0, out_valid=0. in_ready is 1 while in reset.
REQ-030 Reset asserted during HOLD SHALL discard the pending result with no out_valid pulse afterwards.
REQ-031 Reset asserted mid-window SHALL discard all partial samples.

Configuration
REQ-032 Macro RESULT_WINDOW_ACC_MAX_EN: when defined, max tracking SHALL be implemented per REQ-010/017/028.
REQ-033 When RESULT_WINDOW_ACC_MAX_EN is undefined, max SHALL be constant 0, no max comparator or register SHALL be synthesized, and all other behaviour SHALL be unchanged.

Verification (WINDOW=4, macro defined unless stated)
REQ-034 Samples 9, 11, 18, 2 on consecutive cycles, out_ready=1 -> next cycle out_valid=1, sum=40, avg=10, max=18; one cycle later out_valid=0, in_ready=1.
REQ-035 Four samples of 511 with 2-cycle in_valid gaps, out_ready=0 for 5 cycles -> sum=2044, avg=511, max=511 held stable for 5 cycles with in_ready=0; then released on out_ready=1.
REQ-036 Samples 100, 200, then clear=1 together with in_valid=1 on sample 50, then four samples of 5 -> sum=20, avg=5, max=5.
REQ-037 Samples 3, 4, 5, 6, then reset_n=0 for 1 cycle while out_valid=1 -> out_valid=0 and sum=0 immediately; the next four samples of 1 give sum=4.
REQ-038 Macro undefined, samples 9, 11, 18, 2 -> sum=40, avg=10, max=0.
